// File: rtl/word_receiver_pkg.sv
// word_receiver shared types: byte FSM encoding, word geometry
// and default baud/timeout constants.
package word_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int BYTES_PER_WORD     = 4;
  localparam int DEF_CLKS_PER_BIT   = 868;
  localparam int DEF_TIMEOUT_CYCLES = 86800;

endpackage

// File: rtl/word_receiver_if.sv
// Host-side serial line and assembled-word outputs of word_receiver.
// master drives the line; slave is the receiver.
interface word_receiver_if;
  logic        data_in;
  logic [31:0] data_out;
  logic        done;
  logic        frame_err;

  modport master (
    output data_in,
    input  data_out,
    input  done,
    input  frame_err
  );

  modport slave (
    input  data_in,
    output data_out,
    output done,
    output frame_err
  );
endinterface

// File: rtl/word_receiver_uart_byte_rx.sv
// uart_byte_rx: 2-FF synchroniser plus 8N1 byte FSM with
// mid-bit sampling, glitch rejection and stop-bit checking.
module uart_byte_rx
  import word_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_byte_data,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    r_sync;
  rx_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_valid;
  logic          r_ferr;
  logic          w_rx;

  assign w_rx         = r_sync[1];
  assign o_byte_data  = r_shift;
  assign o_byte_valid = r_valid;
  assign o_frame_err  = r_ferr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!w_rx) r_state <= START;
        end
        START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            r_bit <= '0;
            // a start bit gone high by mid-bit is line noise
            r_state <= w_rx ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            r_valid <= w_rx;
            r_ferr  <= !w_rx;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/word_receiver.sv
// word_receiver: UART bytes -> MSB-first 32-bit words with done pulse.
// Define RX_TIMEOUT_EN to drop partial words after TIMEOUT_CYCLES idle.
module word_receiver
  import word_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT   = DEF_CLKS_PER_BIT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic            clk,
  input logic            rst,
  word_receiver_if.slave bus
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [7:0]  w_byte;
  logic        w_valid;
  logic        w_ferr;
  logic        w_tmo;
  logic [1:0]  r_idx;
  logic [23:0] r_stage;
  logic [31:0] r_data;
  logic        r_done;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (bus.data_in),
    .o_byte_data (w_byte),
    .o_byte_valid(w_valid),
    .o_frame_err (w_ferr)
  );

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_idle;

  assign w_tmo = (r_idx != 2'd0) && (r_idle == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle <= '0;
    end else if (w_valid || w_ferr || w_tmo || r_idx == 2'd0) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_stage <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_ferr) begin
        r_idx <= '0;
      end else if (w_valid) begin
        unique case (r_idx)
          2'd0:    r_stage[23:16] <= w_byte;
          2'd1:    r_stage[15:8]  <= w_byte;
          2'd2:    r_stage[7:0]   <= w_byte;
          default: begin
            r_data <= {r_stage, w_byte};
            r_done <= 1'b1;
          end
        endcase
        r_idx <= (r_idx == LAST_IDX) ? 2'd0 : r_idx + 1'b1;
      end else if (w_tmo) begin
        r_idx <= '0;
      end
    end
  end

  assign bus.data_out  = r_data;
  assign bus.done      = r_done;
  assign bus.frame_err = w_ferr;

endmodule

// File: tb/tb_word_receiver.sv
// Directed bench for word_receiver at CLKS_PER_BIT=16.
// Honours RX_TIMEOUT_EN for the timeout expectation.
module tb_word_receiver;

  localparam int CPB = 16;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  word_receiver_if bus ();

  word_receiver #(
    .CLKS_PER_BIT  (CPB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [7:0]  b [4];
    logic [31:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ferr_n = 0;
  int          overlap_n = 0;
  logic [31:0] done_val[$];
  int          done_cyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) begin
        done_val.push_back(bus.data_out);
        done_cyc.push_back(cyc);
      end
      if (bus.frame_err) ferr_n++;
      if (bus.done && bus.frame_err) overlap_n++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.data_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.data_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.data_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.data_in = stop;
    repeat (CPB) @(negedge clk);
    bus.data_in = 1'b1;
  endtask

  task automatic send_word(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.data_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  vec_t vecs[6];

  initial begin
    int d0;
    int f0;
    int gap;
    logic [31:0] exp4;

    vecs[0] = '{'{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 32'hDEADBEEF};
    vecs[1] = '{'{8'h0B, 8'hAD, 8'hC0, 8'hDE}, 32'h0BADC0DE};
    vecs[2] = '{'{8'h00, 8'h00, 8'h00, 8'h01}, 32'h00000001};
    vecs[3] = '{'{8'hFF, 8'hFF, 8'hFF, 8'hFF}, 32'hFFFFFFFF};
    vecs[4] = '{'{8'h80, 8'h00, 8'h00, 8'h01}, 32'h80000001};
    vecs[5] = '{'{8'h5A, 8'h5A, 8'hA5, 8'hA5}, 32'h5A5AA5A5};

    bus.data_in = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data_out", bus.data_out, 32'h0);
    chk("rst_done", {31'b0, bus.done}, 32'h0);
    chk("rst_frame_err", {31'b0, bus.frame_err}, 32'h0);
    rst = 1'b0;
    idle(20);

    for (int i = 0; i < 6; i++) begin
      d0 = done_val.size();
      f0 = ferr_n;
      send_word(vecs[i].b[0], vecs[i].b[1], vecs[i].b[2], vecs[i].b[3]);
      idle(40);
      chk($sformatf("vec%0d_done_n", i), done_val.size() - d0, 1);
      chk($sformatf("vec%0d_data", i), bus.data_out, vecs[i].exp);
      chk($sformatf("vec%0d_ferr_n", i), ferr_n - f0, 0);
    end

    // bad stop bit mid-word realigns to the next byte
    do_reset();
    d0 = done_val.size();
    f0 = ferr_n;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b0);
    idle(48);
    send_word(8'h01, 8'h02, 8'h03, 8'h04);
    idle(40);
    chk("ferr_pulses", ferr_n - f0, 1);
    chk("ferr_done_n", done_val.size() - d0, 1);
    chk("ferr_data", bus.data_out, 32'h01020304);

    // short low glitch on the line is rejected
    d0 = done_val.size();
    f0 = ferr_n;
    bus.data_in = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    chk("glitch_done_n", done_val.size() - d0, 0);
    chk("glitch_ferr_n", ferr_n - f0, 0);
    send_word(8'hCA, 8'hFE, 8'hF0, 8'h0D);
    idle(40);
    chk("glitch_next_done_n", done_val.size() - d0, 1);
    chk("glitch_next_data", bus.data_out, 32'hCAFEF00D);

    // long idle after one byte
`ifdef RX_TIMEOUT_EN
    exp4 = 32'h11223344;
`else
    exp4 = 32'hAA112233;
`endif
    do_reset();
    d0 = done_val.size();
    send_byte(8'hAA, 1'b1);
    idle(300);
    send_word(8'h11, 8'h22, 8'h33, 8'h44);
    idle(40);
    chk("tmo_done_n", done_val.size() - d0, 1);
    chk("tmo_data", bus.data_out, exp4);

    // reset in the middle of the 3rd byte
    do_reset();
    send_word(8'h13, 8'h57, 8'h9B, 8'hDF);
    idle(40);
    chk("pre_rst_data", bus.data_out, 32'h13579BDF);
    d0 = done_val.size();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    bus.data_in = 1'b0;
    repeat (CPB) @(negedge clk);
    bus.data_in = 1'b1;
    repeat (CPB) @(negedge clk);
    bus.data_in = 1'b0;
    repeat (CPB) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    bus.data_in = 1'b1;
    chk("midrst_data_in_rst", bus.data_out, 32'h0);
    rst = 1'b0;
    idle(40);
    chk("midrst_done_n", done_val.size() - d0, 0);
    chk("midrst_data", bus.data_out, 32'h0);
    send_word(8'h00, 8'h00, 8'h00, 8'h01);
    idle(40);
    chk("postrst_done_n", done_val.size() - d0, 1);
    chk("postrst_data", bus.data_out, 32'h00000001);

    // two words back-to-back, no idle between frames
    do_reset();
    d0 = done_val.size();
    send_word(8'h89, 8'hAB, 8'hCD, 8'hEF);
    send_word(8'h10, 8'h32, 8'h54, 8'h76);
    idle(40);
    chk("b2b_done_n", done_val.size() - d0, 2);
    if (done_val.size() >= d0 + 2) begin
      chk("b2b_word0", done_val[d0], 32'h89ABCDEF);
      chk("b2b_word1", done_val[d0+1], 32'h10325476);
      gap = done_cyc[d0+1] - done_cyc[d0];
      checks++;
      if (gap < 40 * CPB - 2 || gap > 40 * CPB + 2) begin
        errors++;
        $display("FAIL b2b_gap: got %0d cycles expected %0d +/-2",
                 gap, 40 * CPB);
      end
    end

    chk("done_ferr_overlap", overlap_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_receiver.md
# word_receiver

Serial receive path for host-to-FPGA traffic. It deserialises an 8N1 UART stream, then assembles four consecutive bytes, most significant byte first, into one 32-bit word. It presents the completed word with a one-cycle `done` pulse. It is the inverse of the 32-bit word transmitter and feeds work words from the host into the mining core.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 8.
- `TIMEOUT_CYCLES`, 86800, idle clocks after a byte before a partial word is discarded (used only with `RX_TIMEOUT_EN`).
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `data_in` in 1: serial RX line; idles high; asynchronous to `clk`.
- `data_out` out 32: last completed word.
- `done` out 1: one-cycle pulse when `data_out` is updated.
- `frame_err` out 1: one-cycle pulse when a byte has a bad stop bit.

## Operation
- `data_in` passes through a 2-FF synchroniser, reset to 1; all decisions use the synchronised value.
- Byte FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when the synchronised line is 0.
  - START: count `CLKS_PER_BIT/2` clocks, then sample.
    - 0 → DATA with the bit counter at 0.
    - 1 → IDLE. This is glitch rejection; no output is produced.
  - DATA: sample every `CLKS_PER_BIT` clocks, LSB first, into the shift register. After the 8th sample → STOP.
  - STOP: sample after `CLKS_PER_BIT` clocks.
    - 1 → byte valid.
    - 0 → `frame_err` pulse and the byte is dropped.
  - STOP always returns to IDLE.
- Word assembly uses a 2-bit byte index, reset to 0.
  - Valid byte at index 0/1/2/3 → staging bits [31:24]/[23:16]/[15:8]/[7:0]; the index then increments.
  - On index 3, the index wraps to 0, `data_out` loads the full staged word and `done` pulses.
  - `frame_err` forces the index to 0, discarding the partial word. `data_out` is unchanged.
- `data_out` holds its value between words. It never shows partially assembled data.

## Timing
- Reset values:
  - `data_out` = 32'h0, `done` = 0, `frame_err` = 0.
  - FSM = IDLE, byte index = 0, synchroniser = 1.
- Latency:
  - Synchroniser: 2 clocks.
  - Byte valid is internal; it asserts on the clock after the stop-bit sample.
  - `done` asserts on the clock after the 4th byte valid, with `data_out` updated on the same edge.
  - `frame_err` asserts on the clock after a bad stop-bit sample.
- `done` and `frame_err` are never high together, and each is high for exactly 1 cycle.
- Back-to-back frames: a start edge immediately after the stop sample is accepted. No extra idle bit is required.
- Reset mid-frame: immediate return to IDLE. The partial byte and partial word are discarded; `data_out` clears to 0.
- There is no flow control. The consumer must take `data_out` before the next `done`; the next completed word overwrites it.

## Configuration
- `RX_TIMEOUT_EN` defined:
  - An idle counter resets on every valid byte and counts while the byte index ≠ 0.
  - At `TIMEOUT_CYCLES` the byte index forces to 0 and the partial word is discarded. There is no pulse.
  - The counter does not run while the index = 0.
- `RX_TIMEOUT_EN` undefined:
  - No counter is built.
  - Word alignment is recovered only by `frame_err` or `rst`.

## Structure
- Shared package holds:
  - The FSM state encoding: IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3.
  - `BYTES_PER_WORD` = 4.
  - The default baud constants.
- One sub-module, `uart_byte_rx`: synchroniser plus byte FSM. It outputs `byte_data[7:0]`, `byte_valid` and `frame_err`. The word assembly and timeout logic live in `word_receiver`.

## Test plan
1. `CLKS_PER_BIT`=16; send bytes 8'hDE, 8'hAD, 8'hBE, 8'hEF → one `done` pulse, `data_out` = 32'hDEADBEEF, `frame_err` never high.
2. Send 8'h12, 8'h34, then a byte with stop bit 0, then 8'h01, 8'h02, 8'h03, 8'h04 → exactly one `frame_err` pulse, then `done` with `data_out` = 32'h01020304.
3. Drive `data_in` low for 4 clocks, then high → no output pulses, FSM back in IDLE. A following word 32'hCAFEF00D is received correctly.
4. `RX_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=200; send 8'hAA, idle 300 clocks, send 8'h11, 8'h22, 8'h33, 8'h44 → `data_out` = 32'h11223344. Without the macro the same stimulus gives `data_out` = 32'hAA112233.
5. Assert `rst` in the middle of the 3rd byte of a word → `data_out` = 0 and no `done`. The next full word 32'h00000001 is received correctly.
6. Two words sent back-to-back with no idle between frames → two `done` pulses, 40×`CLKS_PER_BIT` (±2 clocks) apart, with the correct values.
